// File: rtl/mandelbrot_pkg.sv
// Shared Q8.24 constants and frame-sequencer state encoding for the Mandelbrot
// display path (frame sequencer and render controller).
package mandelbrot_pkg;

    localparam int          MB_FP_W     = 32;
    localparam logic [31:0] MB_DEF_CRE  = 32'hFF80_0000;  // -0.5
    localparam logic [31:0] MB_DEF_CIM  = 32'h0000_0000;
    localparam logic [31:0] MB_DEF_SCALE = 32'h0001_47AE;  // ~0.005 per pixel
    localparam logic [7:0]  MB_DEF_ITER = 8'd64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RENDER  = 3'd2,
        S_WAIT_VS = 3'd3,
        S_SWAP    = 3'd4
    } mb_state_t;

endpackage

// File: rtl/mandelbrot_frame_seq.sv
// Frame sequencer: latches view parameters, launches one render per parameter
// change, waits for vsync after completion and swaps the double framebuffer.
module mandelbrot_frame_seq
    import mandelbrot_pkg::*;
#(
    parameter int               FP_W      = MB_FP_W,
    parameter int               TIMEOUT   = 1 << 24,
    parameter logic [FP_W-1:0]  DEF_CRE   = MB_DEF_CRE,
    parameter logic [FP_W-1:0]  DEF_CIM   = MB_DEF_CIM,
    parameter logic [FP_W-1:0]  DEF_SCALE = MB_DEF_SCALE,
    parameter logic [7:0]       DEF_ITER  = MB_DEF_ITER
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   param_we,
    input  logic signed [FP_W-1:0] param_center_re,
    input  logic signed [FP_W-1:0] param_center_im,
    input  logic signed [FP_W-1:0] param_scale,
    input  logic [7:0]             param_max_iter,
    input  logic                   vsync,
    input  logic                   render_busy,
    input  logic                   render_done,
    output logic                   render_start,
    output logic signed [FP_W-1:0] center_re,
    output logic signed [FP_W-1:0] center_im,
    output logic signed [FP_W-1:0] scale,
    output logic [7:0]             max_iter,
    output logic                   wr_buf_sel,
    output logic                   rd_buf_sel,
    output logic [15:0]            frame_cnt,
    output logic                   busy,
    output logic                   err,
    output mb_state_t              state_dbg
);

    // Handshake: param_we, vsync and render_done are single-cycle strobes sampled
    // on the rising edge; render_start is a registered one-cycle pulse with no
    // back-pressure, and render_busy only gates the launch decision.

    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT - 1);

    mb_state_t state, state_nxt;

    logic signed [FP_W-1:0] sh_cre, sh_cim, sh_scale;
    logic [7:0]             sh_iter;
    logic                   dirty;
    logic [31:0]            wd;

    logic launch, expire, swap, start_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (dirty && !render_busy) state_nxt = S_LAUNCH;
            S_LAUNCH:  state_nxt = S_RENDER;
            // Completion wins over a watchdog expiry in the same cycle.
            S_RENDER:  if (render_done)          state_nxt = S_WAIT_VS;
                       else if (wd == WD_LIMIT)  state_nxt = S_IDLE;
            S_WAIT_VS: if (vsync) state_nxt = S_SWAP;
            S_SWAP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        launch    = (state == S_IDLE) && dirty && !render_busy;
        expire    = (state == S_RENDER) && !render_done && (wd == WD_LIMIT);
        swap      = (state == S_SWAP);
        start_nxt = (state == S_LAUNCH);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_cre       <= DEF_CRE;
            sh_cim       <= DEF_CIM;
            sh_scale     <= DEF_SCALE;
            sh_iter      <= DEF_ITER;
            center_re    <= DEF_CRE;
            center_im    <= DEF_CIM;
            scale        <= DEF_SCALE;
            max_iter     <= DEF_ITER;
            dirty        <= 1'b1;
            wd           <= '0;
            render_start <= 1'b0;
            wr_buf_sel   <= 1'b1;
            rd_buf_sel   <= 1'b0;
            frame_cnt    <= '0;
            err          <= 1'b0;
        end else begin
            render_start <= start_nxt;

            if (param_we) begin
                sh_cre   <= param_center_re;
                sh_cim   <= param_center_im;
                sh_scale <= param_scale;
                sh_iter  <= param_max_iter;
            end

            // A write landing on the launch edge keeps dirty set so it renders next.
            if (param_we)    dirty <= 1'b1;
            else if (launch) dirty <= 1'b0;
            else if (expire) dirty <= 1'b1;

            if (launch) begin
                center_re  <= sh_cre;
                center_im  <= sh_cim;
                scale      <= sh_scale;
                max_iter   <= sh_iter;
                wr_buf_sel <= ~rd_buf_sel;
            end

            if (state == S_LAUNCH)      wd <= '0;
            else if (state == S_RENDER) wd <= wd + 32'd1;

            if (expire) err <= 1'b1;

            if (swap) begin
                rd_buf_sel <= wr_buf_sel;
                frame_cnt  <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_frame_seq.sv
// Directed bench for mandelbrot_frame_seq: cycle-exact launch/swap timing,
// a per-cycle vector table, counter wrap, mid-render reset and watchdog retry.
module tb_mandelbrot_frame_seq;
    import mandelbrot_pkg::*;

    localparam logic [31:0] D_CRE   = 32'hFF80_0000;
    localparam logic [31:0] D_SCALE = 32'h0001_47AE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // DUT A: default watchdog
    logic        rst_n = 1'b0;
    logic        param_we = 1'b0;
    logic [31:0] p_cre = D_CRE, p_cim = 32'h0, p_scale = D_SCALE;
    logic [7:0]  p_iter = 8'd64;
    logic        vsync = 1'b0, r_busy = 1'b0, r_done = 1'b0;
    logic        start, wr_sel, rd_sel, busy, err;
    logic [31:0] o_cre, o_cim, o_scale;
    logic [7:0]  o_iter;
    logic [15:0] fcnt;
    mb_state_t   st;

    mandelbrot_frame_seq dut (
        .clk(clk), .rst_n(rst_n), .param_we(param_we),
        .param_center_re(p_cre), .param_center_im(p_cim), .param_scale(p_scale),
        .param_max_iter(p_iter), .vsync(vsync), .render_busy(r_busy), .render_done(r_done),
        .render_start(start), .center_re(o_cre), .center_im(o_cim), .scale(o_scale),
        .max_iter(o_iter), .wr_buf_sel(wr_sel), .rd_buf_sel(rd_sel), .frame_cnt(fcnt),
        .busy(busy), .err(err), .state_dbg(st)
    );

    // DUT B: short watchdog
    logic        b_rst_n = 1'b0;
    logic        b_vsync = 1'b0, b_done = 1'b0;
    logic        b_start, b_wr, b_rd, b_busy, b_err;
    logic [31:0] b_cre, b_cim, b_scale;
    logic [7:0]  b_iter;
    logic [15:0] b_fcnt;
    mb_state_t   b_st;

    mandelbrot_frame_seq #(.TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .param_we(1'b0),
        .param_center_re(32'h0), .param_center_im(32'h0), .param_scale(32'h0),
        .param_max_iter(8'h0), .vsync(b_vsync), .render_busy(1'b0), .render_done(b_done),
        .render_start(b_start), .center_re(b_cre), .center_im(b_cim), .scale(b_scale),
        .max_iter(b_iter), .wr_buf_sel(b_wr), .rd_buf_sel(b_rd), .frame_cnt(b_fcnt),
        .busy(b_busy), .err(b_err), .state_dbg(b_st)
    );

    typedef struct {
        logic        pwe;
        logic [31:0] scale_in;
        logic        rbusy;
        logic        rdone;
        logic        vs;
        mb_state_t   st;
        logic        start;
        logic        wr;
        logic        rd;
        logic [15:0] cnt;
        logic [31:0] scale;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        vecs[0]  = '{0, 32'h0,     0, 0, 0, S_IDLE,    0, 1, 1, 16'd1, D_SCALE};
        vecs[1]  = '{1, 32'h10000, 1, 0, 0, S_IDLE,    0, 1, 1, 16'd1, D_SCALE};
        vecs[2]  = '{0, 32'h0,     1, 0, 0, S_IDLE,    0, 1, 1, 16'd1, D_SCALE};
        vecs[3]  = '{0, 32'h0,     0, 0, 0, S_LAUNCH,  0, 0, 1, 16'd1, 32'h10000};
        vecs[4]  = '{0, 32'h0,     0, 0, 0, S_RENDER,  1, 0, 1, 16'd1, 32'h10000};
        vecs[5]  = '{1, 32'h20000, 0, 0, 0, S_RENDER,  0, 0, 1, 16'd1, 32'h10000};
        vecs[6]  = '{0, 32'h0,     0, 0, 1, S_RENDER,  0, 0, 1, 16'd1, 32'h10000};
        vecs[7]  = '{0, 32'h0,     0, 1, 0, S_WAIT_VS, 0, 0, 1, 16'd1, 32'h10000};
        vecs[8]  = '{0, 32'h0,     0, 1, 0, S_WAIT_VS, 0, 0, 1, 16'd1, 32'h10000};
        vecs[9]  = '{0, 32'h0,     0, 0, 1, S_SWAP,    0, 0, 1, 16'd1, 32'h10000};
        vecs[10] = '{0, 32'h0,     0, 0, 0, S_IDLE,    0, 0, 0, 16'd2, 32'h10000};
        vecs[11] = '{0, 32'h0,     0, 0, 0, S_LAUNCH,  0, 1, 0, 16'd2, 32'h20000};
        vecs[12] = '{0, 32'h0,     0, 0, 0, S_RENDER,  1, 1, 0, 16'd2, 32'h20000};
        vecs[13] = '{0, 32'h0,     0, 1, 0, S_WAIT_VS, 0, 1, 0, 16'd2, 32'h20000};
        vecs[14] = '{0, 32'h0,     0, 0, 1, S_SWAP,    0, 1, 0, 16'd2, 32'h20000};
        vecs[15] = '{0, 32'h0,     0, 0, 0, S_IDLE,    0, 1, 1, 16'd3, 32'h20000};
        vecs[16] = '{0, 32'h0,     0, 0, 0, S_IDLE,    0, 1, 1, 16'd3, 32'h20000};
        vecs[17] = '{1, 32'h30000, 1, 0, 0, S_IDLE,    0, 1, 1, 16'd3, 32'h20000};
        vecs[18] = '{1, 32'h40000, 0, 0, 0, S_LAUNCH,  0, 0, 1, 16'd3, 32'h30000};
        vecs[19] = '{0, 32'h0,     0, 0, 0, S_RENDER,  1, 0, 1, 16'd3, 32'h30000};
        vecs[20] = '{0, 32'h0,     0, 1, 0, S_WAIT_VS, 0, 0, 1, 16'd3, 32'h30000};
        vecs[21] = '{0, 32'h0,     0, 0, 1, S_SWAP,    0, 0, 1, 16'd3, 32'h30000};
        vecs[22] = '{0, 32'h0,     0, 0, 0, S_IDLE,    0, 0, 0, 16'd4, 32'h30000};
        vecs[23] = '{0, 32'h0,     0, 0, 0, S_LAUNCH,  0, 1, 0, 16'd4, 32'h40000};
        vecs[24] = '{0, 32'h0,     0, 0, 0, S_RENDER,  1, 1, 0, 16'd4, 32'h40000};
        vecs[25] = '{0, 32'h0,     0, 1, 0, S_WAIT_VS, 0, 1, 0, 16'd4, 32'h40000};
        vecs[26] = '{0, 32'h0,     0, 0, 1, S_SWAP,    0, 1, 0, 16'd4, 32'h40000};
        vecs[27] = '{0, 32'h0,     0, 0, 0, S_IDLE,    0, 1, 1, 16'd5, 32'h40000};
        vecs[28] = '{0, 32'h0,     0, 0, 0, S_IDLE,    0, 1, 1, 16'd5, 32'h40000};

        // Reset values while held in reset
        step(); step(); step();
        chk("rst state", 32'(st), 32'(S_IDLE));
        chk("rst start", 32'(start), 32'd0);
        chk("rst wr_sel", 32'(wr_sel), 32'd1);
        chk("rst rd_sel", 32'(rd_sel), 32'd0);
        chk("rst frame_cnt", 32'(fcnt), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst center_re", o_cre, D_CRE);
        chk("rst center_im", o_cim, 32'h0);
        chk("rst scale", o_scale, D_SCALE);
        chk("rst max_iter", 32'(o_iter), 32'd64);

        // First frame with exact cycle timing
        rst_n = 1'b1;
        cyc = 0;
        step();
        chk("c1 state", 32'(st), 32'(S_LAUNCH));
        chk("c1 start", 32'(start), 32'd0);
        step();
        chk("c2 start", 32'(start), 32'd1);
        chk("c2 state", 32'(st), 32'(S_RENDER));
        chk("c2 center_re", o_cre, D_CRE);
        chk("c2 max_iter", 32'(o_iter), 32'd64);
        chk("c2 wr_sel", 32'(wr_sel), 32'd1);
        chk("c2 rd_sel", 32'(rd_sel), 32'd0);
        step();
        chk("c3 start", 32'(start), 32'd0);
        run_to(50);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        chk("vsync in render", 32'(st), 32'(S_RENDER));
        run_to(100);
        r_done = 1'b1;
        step();
        r_done = 1'b0;
        chk("c101 state", 32'(st), 32'(S_WAIT_VS));
        run_to(120);
        r_done = 1'b1;
        step();
        r_done = 1'b0;
        chk("done in wait_vs", 32'(st), 32'(S_WAIT_VS));
        run_to(150);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        chk("c151 state", 32'(st), 32'(S_SWAP));
        chk("c151 rd_sel", 32'(rd_sel), 32'd0);
        step();
        chk("c152 rd_sel", 32'(rd_sel), 32'd1);
        chk("c152 frame_cnt", 32'(fcnt), 32'd1);
        chk("c152 state", 32'(st), 32'(S_IDLE));
        begin
            int relaunch = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (st != S_IDLE || start) relaunch++;
            end
            chk("no relaunch when clean", 32'(relaunch), 32'd0);
        end

        // Per-cycle table
        for (int i = 0; i < 29; i++) begin
            param_we = vecs[i].pwe;
            p_scale  = vecs[i].pwe ? vecs[i].scale_in : D_SCALE;
            r_busy   = vecs[i].rbusy;
            r_done   = vecs[i].rdone;
            vsync    = vecs[i].vs;
            step();
            param_we = 1'b0;
            r_busy = 1'b0;
            r_done = 1'b0;
            vsync = 1'b0;
            chk($sformatf("row%0d state", i), 32'(st), 32'(vecs[i].st));
            chk($sformatf("row%0d start", i), 32'(start), 32'(vecs[i].start));
            chk($sformatf("row%0d wr_sel", i), 32'(wr_sel), 32'(vecs[i].wr));
            chk($sformatf("row%0d rd_sel", i), 32'(rd_sel), 32'(vecs[i].rd));
            chk($sformatf("row%0d frame_cnt", i), 32'(fcnt), 32'(vecs[i].cnt));
            chk($sformatf("row%0d scale", i), o_scale, vecs[i].scale);
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].st != S_IDLE));
            if (vecs[i].st == S_RENDER)
                chk($sformatf("row%0d bufs differ", i), 32'(wr_sel != rd_sel), 32'd1);
        end

        // frame_cnt wrap
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        chk("preload frame_cnt", 32'(fcnt), 32'hFFFF);
        param_we = 1'b1;
        p_scale = 32'h50000;
        step();
        param_we = 1'b0;
        step();
        chk("wrap launch", 32'(st), 32'(S_LAUNCH));
        step();
        r_done = 1'b1;
        step();
        r_done = 1'b0;
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        chk("wrap swap", 32'(st), 32'(S_SWAP));
        step();
        chk("wrap frame_cnt", 32'(fcnt), 32'h0000);

        // Reset in the middle of a render
        param_we = 1'b1;
        p_scale = 32'h60000;
        step();
        param_we = 1'b0;
        step();
        step();
        chk("pre-reset state", 32'(st), 32'(S_RENDER));
        chk("pre-reset scale", o_scale, 32'h60000);
        rst_n = 1'b0;
        #1;
        chk("mid reset state", 32'(st), 32'(S_IDLE));
        chk("mid reset scale", o_scale, D_SCALE);
        chk("mid reset wr_sel", 32'(wr_sel), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("relaunch state", 32'(st), 32'(S_LAUNCH));
        chk("relaunch scale", o_scale, D_SCALE);
        step();
        chk("relaunch start", 32'(start), 32'd1);

        // Watchdog on DUT B
        b_rst_n = 1'b1;
        step();
        chk("b launch", 32'(b_st), 32'(S_LAUNCH));
        step();
        chk("b start", 32'(b_start), 32'd1);
        for (int i = 0; i < 15; i++) step();
        chk("b before expiry state", 32'(b_st), 32'(S_RENDER));
        chk("b before expiry err", 32'(b_err), 32'd0);
        step();
        chk("b expiry state", 32'(b_st), 32'(S_IDLE));
        chk("b expiry err", 32'(b_err), 32'd1);
        chk("b expiry rd_sel", 32'(b_rd), 32'd0);
        chk("b expiry frame_cnt", 32'(b_fcnt), 32'd0);
        step();
        chk("b retry state", 32'(b_st), 32'(S_LAUNCH));
        chk("b retry wr_sel", 32'(b_wr), 32'd1);
        step();
        chk("b retry start", 32'(b_start), 32'd1);
        for (int i = 0; i < 15; i++) step();
        b_done = 1'b1;
        step();
        b_done = 1'b0;
        chk("b done beats expiry", 32'(b_st), 32'(S_WAIT_VS));
        b_vsync = 1'b1;
        step();
        b_vsync = 1'b0;
        step();
        chk("b swap rd_sel", 32'(b_rd), 32'd1);
        chk("b swap frame_cnt", 32'(b_fcnt), 32'd1);
        chk("b err sticky", 32'(b_err), 32'd1);
        b_rst_n = 1'b0;
        #1;
        chk("b err cleared by reset", 32'(b_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mandelbrot_frame_seq.md
MANDELBROT_FRAME_SEQ -- requirements
Module: mandelbrot_frame_seq

Interface
REQ-001 SHALL have parameter FP_W, default 32, meaning fixed-point word width (Q8.24).
REQ-002 SHALL have parameter TIMEOUT, default 2^24, meaning the watchdog limit in cycles for one render.
REQ-003 SHALL have parameters DEF_CRE = 32'hFF800000 (-0.5), DEF_CIM = 0, DEF_SCALE = 32'h0001_47AE (about 0.005), DEF_ITER = 8'd64, meaning the power-on view.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 param_we  in  1  one-cycle strobe that captures the four param_* inputs.
REQ-008 param_center_re, param_center_im, param_scale  in  FP_W (signed)  requested view.
REQ-009 param_max_iter  in  8  requested iteration limit.
REQ-010 vsync  in  1  one-cycle pulse at display frame start, synchronous to clk.
REQ-011 render_busy, render_done  in  1  status from the render controller.
REQ-012 render_start  out  1  one-cycle launch pulse to the render controller.
REQ-013 center_re, center_im, scale  out  FP_W; max_iter  out  8  active frame parameters.
REQ-014 wr_buf_sel, rd_buf_sel  out  1  render and display framebuffer selects.
REQ-015 frame_cnt  out  16  count of completed swaps; busy  out  1; err  out  1 (sticky).

Function
REQ-016 Shadow registers SHALL load all param_* inputs on param_we and set the dirty flag.
REQ-017 The FSM SHALL have states S_IDLE, S_LAUNCH, S_RENDER, S_WAIT_VS and S_SWAP; busy = (state != S_IDLE).
REQ-018 In S_IDLE with dirty=1 and render_busy=0, the next edge SHALL enter S_LAUNCH, copy shadow to active outputs, set wr_buf_sel = ~rd_buf_sel and clear dirty.
REQ-019 If param_we coincides with that transition, the new values SHALL go to shadow and dirty SHALL remain 1; active outputs SHALL take the pre-write shadow.
REQ-020 In S_LAUNCH the block SHALL register render_start=1 for exactly one cycle and clear the watchdog, so render_start is high in the first S_RENDER cycle (two edges after the S_IDLE decision).
REQ-021 Active parameter outputs and wr_buf_sel SHALL change only on the S_IDLE->S_LAUNCH edge.
REQ-022 In S_RENDER, render_done=1 SHALL move the FSM to S_WAIT_VS; vsync SHALL be ignored and not latched.
REQ-023 In S_RENDER the watchdog SHALL increment each cycle; when it reaches TIMEOUT-1 without render_done, the block SHALL set err, set dirty (retry) and return to S_IDLE without swapping.
REQ-024 If render_done and watchdog expiry coincide, done SHALL take priority.
REQ-025 In S_WAIT_VS, vsync=1 SHALL move the FSM to S_SWAP; render_done there SHALL be ignored.
REQ-026 S_SWAP SHALL set rd_buf_sel <= wr_buf_sel, increment frame_cnt modulo 2^16 (0xFFFF->0) and return to S_IDLE in one cycle.
REQ-027 param_we while busy SHALL only update shadow; the next frame SHALL render it after the swap.
REQ-028 rd_buf_sel SHALL never equal wr_buf_sel while in S_RENDER.

Reset
REQ-029 On rst_n=0 the block SHALL set: state S_IDLE, render_start 0, wr_buf_sel 1, rd_buf_sel 0, frame_cnt 0, err 0, watchdog 0, active and shadow params at DEF_*, dirty 1.
REQ-030 Reset mid-render SHALL abandon the frame; after release the block SHALL relaunch with the defaults.
REQ-031 err SHALL clear only on reset.

Structure
REQ-032 The Q8.24 default constants, FP_W and the state encoding SHALL live in shared package mandelbrot_pkg, used by this block and mandelbrot_render_ctrl.
REQ-033 The block SHALL have no sub-module; the watchdog is an inline counter.

Verification
REQ-034 Reset release, render_busy=0 -> render_start pulse on cycle 2 with center_re=0xFF800000, max_iter=64, wr_buf_sel=1.
REQ-035 render_done at cycle 100, vsync at 150 -> rd_buf_sel=1 and frame_cnt=1 at cycle 152; no second launch while dirty=0.
REQ-036 param_we (scale=0x00010000) during S_RENDER -> scale output unchanged until after the swap; second launch uses 0x00010000 and wr_buf_sel=0.
REQ-037 TIMEOUT=16, render_done withheld -> err=1 on cycle 16 after start, no swap, relaunch with same buffer.
REQ-038 vsync pulses during S_RENDER and render_done during S_WAIT_VS -> no state effect; swap only on first vsync after done.
REQ-039 frame_cnt preloaded to 0xFFFF via 65535 frames (or force) -> wraps to 0x0000 on next swap.
